sipo_deframer: RTL and testbench

- Downstream consumer of the 4-bit serial-in/serial-out delay line: samples its serial output, detects a start bit, and collects WIDTH data bits LSB-first.
- Optionally checks an even-parity bit after the data bits.
- Presents each completed word on a parallel valid/ready interface through a single holding register.
- Sits between the serial delay stage and word-level logic; one bit per enabled clock.

---
 rtl/sipo_deframer.sv | 115 +++++++++++
 tb/tb_sipo_deframer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sipo_deframer.sv
// ============================================================================
// Module   : sipo_deframer
// Purpose  : Serial start-bit deframer, LSB-first data, optional even parity,
//            single-entry valid/ready holding register with overrun pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sipo_deframer #(
   parameter int WIDTH     = 4,
   parameter int PARITY_EN = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             si,
   input  logic             bit_en,
   output logic [WIDTH-1:0] data_out,
   output logic             valid,
   input  logic             ready,
   output logic             par_err,
   output logic             overrun
);

   localparam int             c_cw   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [c_cw-1:0] c_last = c_cw'(WIDTH - 1);
   localparam bit             c_par  = (PARITY_EN != 0);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2
   } state_t;

   state_t            r_state;
   logic [c_cw-1:0]   r_cnt;
   logic [WIDTH-1:0]  r_shift;

   logic [WIDTH-1:0]  w_word;
   logic              w_perr;
   logic              w_complete;

   // w_word already contains the bit being sampled, so a frame without
   // parity can complete on its last data bit without an extra cycle.
   always_comb begin
      w_word     = r_shift;
      w_perr     = 1'b0;
      w_complete = 1'b0;
      case (r_state)
         ST_DATA: begin
            w_word[r_cnt] = si;
            if (bit_en && (r_cnt == c_last) && !c_par)
               w_complete = 1'b1;
         end
         ST_PARITY: begin
            w_perr     = (^r_shift) ^ si;
            w_complete = bit_en;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_shift <= '0;
      end else if (bit_en) begin
         case (r_state)
            ST_IDLE: begin
               if (si) begin
                  r_state <= ST_DATA;
                  r_cnt   <= '0;
               end
            end
            ST_DATA: begin
               r_shift <= w_word;
               if (r_cnt == c_last) begin
                  r_state <= c_par ? ST_PARITY : ST_IDLE;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + c_cw'(1);
               end
            end
            ST_PARITY: r_state <= ST_IDLE;
            default:   r_state <= ST_IDLE;
         endcase
      end
   end

   // A consume and a completion in the same cycle hand over directly.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_out <= '0;
         valid    <= 1'b0;
         par_err  <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (valid && ready)
            valid <= 1'b0;
         if (w_complete) begin
            if (!valid || ready) begin
               data_out <= w_word;
               par_err  <= w_perr;
               valid    <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_sipo_deframer.sv
// ============================================================================
// Module   : tb_sipo_deframer
// Purpose  : Directed scoreboard bench for sipo_deframer (WIDTH=4, parity on).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sipo_deframer;

   logic       clk;
   logic       rst;
   logic       si;
   logic       bit_en;
   logic [3:0] data_out;
   logic       valid;
   logic       ready;
   logic       par_err;
   logic       overrun;

   int checks   = 0;
   int failures = 0;
   int n_push   = 0;
   int n_pop    = 0;
   int n_ovr    = 0;

   logic [4:0] exp_q[$];

   sipo_deframer #(.WIDTH(4), .PARITY_EN(1)) dut (
      .clk      (clk),
      .rst      (rst),
      .si       (si),
      .bit_en   (bit_en),
      .data_out (data_out),
      .valid    (valid),
      .ready    (ready),
      .par_err  (par_err),
      .overrun  (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: a word is consumed at the edge following a negedge with valid&ready.
   always @(negedge clk) begin
      if (!rst && valid && ready) begin
         logic [4:0] e;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_word: got data=%0h perr=%0b expected none", data_out, par_err);
         end else begin
            e = exp_q.pop_front();
            n_pop++;
            chk("word_data", 32'(data_out), 32'(e[3:0]));
            chk("word_perr", 32'(par_err), 32'(e[4]));
         end
      end
      if (!rst && overrun) n_ovr++;
   end

   task automatic push(input logic [3:0] d, input logic pe);
      exp_q.push_back({pe, d});
      n_push++;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      si     = b;
      bit_en = 1'b1;
      cyc();
   endtask

   task automatic idle_gap();
      bit_en = 1'b0;
      si     = ~si;
      cyc();
      si     = ~si;
      cyc();
   endtask

   task automatic send_frame(input logic [3:0] d, input logic p, input bit gaps,
                             input bit set_rdy, input logic rdy_last);
      send_bit(1'b1);
      for (int i = 0; i < 4; i++) begin
         send_bit(d[i]);
         if (gaps) idle_gap();
      end
      if (set_rdy) ready = rdy_last;
      send_bit(p);
      bit_en = 1'b0;
      si     = 1'b0;
   endtask

   task automatic consume();
      ready = 1'b1;
      cyc();
      ready = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; si = 1'b1; bit_en = 1'b1; ready = 1'b0;
      cyc();
      cyc();
      chk("rst_valid",   32'(valid),    32'h0);
      chk("rst_data",    32'(data_out), 32'h0);
      chk("rst_overrun", 32'(overrun),  32'h0);
      chk("rst_perr",    32'(par_err),  32'h0);
      rst = 1'b0; bit_en = 1'b0; si = 1'b0;
      cyc();
      chk("idle_valid", 32'(valid), 32'h0);

      // Good frame, held while ready=0
      push(4'b1101, 1'b0);
      send_frame(4'b1101, 1'b1, 0, 0, 1'b0);
      chk("good_valid", 32'(valid), 32'h1);
      repeat (3) cyc();
      chk("hold_valid", 32'(valid),    32'h1);
      chk("hold_data",  32'(data_out), 32'hd);
      consume();
      chk("consumed_valid", 32'(valid),    32'h0);
      chk("kept_data",      32'(data_out), 32'hd);

      // Parity error
      push(4'b1101, 1'b1);
      send_frame(4'b1101, 1'b0, 0, 0, 1'b0);
      chk("perr_valid", 32'(valid),   32'h1);
      chk("perr_flag",  32'(par_err), 32'h1);
      consume();

      // Overrun: second word dropped
      push(4'b1101, 1'b0);
      send_frame(4'b1101, 1'b1, 0, 0, 1'b0);
      send_frame(4'b0100, 1'b1, 0, 0, 1'b0);
      chk("ovr_pulse", 32'(overrun), 32'h1);
      cyc();
      chk("ovr_clear", 32'(overrun),  32'h0);
      chk("ovr_data",  32'(data_out), 32'hd);
      chk("ovr_valid", 32'(valid),    32'h1);
      consume();

      // Same pair, ready=1 on the second frame's last bit: direct handover
      push(4'b1101, 1'b0);
      send_frame(4'b1101, 1'b1, 0, 0, 1'b0);
      push(4'b0100, 1'b0);
      send_frame(4'b0100, 1'b1, 0, 1, 1'b1);
      chk("hand_noovr", 32'(overrun),  32'h0);
      chk("hand_data",  32'(data_out), 32'h4);
      chk("hand_valid", 32'(valid),    32'h1);
      cyc();
      ready = 1'b0;
      chk("hand_drained", 32'(valid), 32'h0);

      // bit_en gaps between data bits
      push(4'b0010, 1'b0);
      send_frame(4'b0010, 1'b1, 1, 0, 1'b0);
      chk("gap_data", 32'(data_out), 32'h2);
      chk("gap_perr", 32'(par_err),  32'h0);
      consume();

      // Reset mid-frame, then a full frame
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b1);
      bit_en = 1'b0;
      rst    = 1'b1;
      cyc();
      rst = 1'b0;
      chk("midrst_valid", 32'(valid), 32'h0);
      push(4'b1111, 1'b0);
      send_frame(4'b1111, 1'b0, 0, 0, 1'b0);
      chk("midrst_data",  32'(data_out), 32'hf);
      chk("midrst_valid2", 32'(valid),   32'h1);
      consume();
      repeat (4) cyc();
      chk("midrst_single", 32'(valid), 32'h0);

      chk("queue_empty", 32'(exp_q.size()), 32'h0);
      chk("pop_count",   32'(n_pop),        32'(n_push));
      chk("ovr_count",   32'(n_ovr),        32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
